multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing controller for the multicycle ARM datapath: a Moore state machine that drives the shared ALU, memory, register file, PC and instruction register across several cycles per instruction. It owns the NZCV flag register and evaluates the condition field once per instruction, gating every architectural write. It sits between the instruction register fields and the datapath multiplexer and enable controls.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S/L
- Rd  in  4  instr[15:12]
- Cond  in  4  instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- mem_ready  in  1  memory done; used only with MC_MEM_HANDSHAKE_EN
- PCWrite, MemWrite, RegWrite, IRWrite  out  1  write enables
- AdrSrc, ALUSrcA  out  1  mux selects
- ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc  out  2  mux selects / ALU op
- FLAGS  out  4  flag register {N,Z,C,V}
- state  out  4  current state, debug

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 go to FETCH next cycle, all outputs 0.
- Transitions: FETCH->DECODE. DECODE: Op=01->MEMADR; Op=00,Funct[5]=0->EXECUTER; Op=00,Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH. MEMADR: Funct[0]=1->MEMREAD else MEMWRITE. MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Per-state controls (unlisted = 0): FETCH: IRWrite, NextPC, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR: ALUSrcB=01. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegW. MEMWRITE: AdrSrc=1, MemW. EXECUTER: ALUOp. EXECUTEI: ALUSrcB=01, ALUOp. ALUWB: RegW. BRANCH: ALUSrcB=01, ResultSrc=10, Branch.
- ALU decode when ALUOp=1: cmd 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01 with NoWrite=1; other cmd->00. FlagW[1]=Funct[0]; FlagW[0]=Funct[0]&(ADD|SUB|CMP). ALUOp=0: ALUControl=00, FlagW=00.
- ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01), combinational from inputs in every state.
- CondEx from FLAGS per ARM codes 0000 EQ .. 1110 AL (N=bit3, Z=bit2, C=bit1, V=bit0); 1111 -> 0. Registered into cond_q on the DECODE->next edge; held until next DECODE.
- Gated outputs: PCWrite=NextPC|(cond_q&(Branch|(RegW&Rd==15))); RegWrite=RegW&cond_q&~NoWrite(evaluated from Funct); MemWrite=MemW&cond_q.
- Flag register: FLAGS[3:2]<=ALUFlags[3:2] when FlagW[1]&cond_q; FLAGS[1:0]<=ALUFlags[1:0] when FlagW[0]&cond_q; only in EXECUTER/EXECUTEI.

## Timing
- Reset (sync): state=FETCH, FLAGS=0000, cond_q=0. While reset=1 all write enables 0, selects at FETCH values.
- Cycles/instruction: LDR 5, STR 4, data-processing 4, branch 3, Op=11 2.
- Condition uses flags before the instruction; flags written by an instruction visible from its ALUWB cycle onward.
- Failed condition: state sequence unchanged, only writes suppressed.
- Reset mid-instruction: next cycle FETCH, no partial writes after reset edge.

## Configuration
- MC_MEM_HANDSHAKE_EN defined: FETCH, MEMREAD, MEMWRITE hold while mem_ready=0; IRWrite and FETCH PCWrite asserted only in the cycle mem_ready=1; MemWrite held asserted throughout MEMWRITE until mem_ready=1.
- Not defined: mem_ready ignored; each of those states lasts one cycle.

## Test plan
- Reset, then Op=00 Funct=101000 (ADD imm, S=0), Cond=1110 -> states 0,1,7,8,0; RegWrite=1 in ALUWB only; FLAGS stay 0000.
- CMP (Funct=010101) with ALUFlags=0100 -> FLAGS=0100 after EXECUTER; RegWrite=0 in ALUWB.
- FLAGS=0100, branch Cond=0001 (NE) -> states 0,1,9,0, PCWrite=0 in BRANCH; Cond=0000 -> PCWrite=1.
- LDR (Op=01, Funct[0]=1) with Rd=15 -> states 0,1,2,3,4,0; PCWrite and RegWrite=1 in MEMWB.
- With MC_MEM_HANDSHAKE_EN, STR with mem_ready low 3 cycles in MEMWRITE -> state 5 held, MemWrite=1 for 4 cycles, then FETCH.
- Reset asserted in MEMREAD -> next state FETCH, FLAGS=0000, no RegWrite.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: Moore FSM, ALU decode, NZCV flags, condition gating.
// Optional MC_MEM_HANDSHAKE_EN makes FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] FLAGS,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     cur_state, next_state;
  logic       mem_done;
  logic       next_pc, ir_w, reg_w, mem_w, branch, alu_op;
  logic       cond_ex, cond_q, no_write;
  logic [1:0] flag_w;
  logic [3:0] cmd;

`ifdef MC_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign cmd   = Funct[4:1];
  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      FLAGS     <= 4'b0000;
      cond_q    <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_DECODE) cond_q <= cond_ex;
      if ((cur_state == S_EXECUTER || cur_state == S_EXECUTEI) && cond_q) begin
        if (flag_w[1]) FLAGS[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) FLAGS[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    next_pc    = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (cur_state)
      S_FETCH: begin
        ir_w       = mem_done;
        next_pc    = mem_done;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = mem_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   next_state = S_MEMADR;
          2'b00:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_done ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        next_state = mem_done ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    // While reset is held the datapath sees a quiet FETCH: selects parked, nothing written.
    if (reset) begin
      next_pc   = 1'b0;
      ir_w      = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      alu_op    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b1;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end
  end

  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010);
    end
  end

  // CMP writes flags only; memory Funct bits alias the cmd field, so qualify by Op.
  assign no_write = (Op == 2'b00) && (cmd == 4'b1010);

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = FLAGS[2];
      4'b0001: cond_ex = ~FLAGS[2];
      4'b0010: cond_ex = FLAGS[1];
      4'b0011: cond_ex = ~FLAGS[1];
      4'b0100: cond_ex = FLAGS[3];
      4'b0101: cond_ex = ~FLAGS[3];
      4'b0110: cond_ex = FLAGS[0];
      4'b0111: cond_ex = ~FLAGS[0];
      4'b1000: cond_ex = FLAGS[1] & ~FLAGS[2];
      4'b1001: cond_ex = ~(FLAGS[1] & ~FLAGS[2]);
      4'b1010: cond_ex = (FLAGS[3] == FLAGS[0]);
      4'b1011: cond_ex = (FLAGS[3] != FLAGS[0]);
      4'b1100: cond_ex = ~FLAGS[2] & (FLAGS[3] == FLAGS[0]);
      4'b1101: cond_ex = FLAGS[2] | (FLAGS[3] != FLAGS[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign PCWrite  = next_pc | (cond_q & (branch | (reg_w & (Rd == 4'hF))));
  assign RegWrite = reg_w & cond_q & ~no_write;
  assign MemWrite = mem_w & cond_q;
  assign IRWrite  = ir_w;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller; one row per clock cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       mem_ready;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0] FLAGS, state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FLAGS(FLAGS), .state(state)
  );

  always #5 clk = ~clk;

  // wr = {PCWrite, MemWrite, RegWrite, IRWrite}; sel = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cond, af;
    logic       mr;
    logic [3:0] st, wr, flags;
    logic [5:0] sel;
    logic [1:0] aluctl;
  } vec_t;

  localparam logic [5:0] SEL_FD = 6'b011010, SEL_B1 = 6'b000100, SEL_AD = 6'b100000;
  localparam logic [5:0] SEL_WB = 6'b000001, SEL_NO = 6'b000000, SEL_BR = 6'b000110;

  vec_t       vecs[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] c_op;
  logic [5:0] c_funct;
  logic [3:0] c_rd, c_cond, c_af;
  logic       c_mr;

  task automatic instr(input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, cond, af);
    c_op = op; c_funct = funct; c_rd = rd; c_cond = cond; c_af = af;
  endtask

  task automatic row(input logic rst, mr, input logic [3:0] st, wr, input logic [5:0] sel,
                     input logic [1:0] aluctl, input logic [3:0] flags);
    vec_t v;
    v.rst = rst; v.op = c_op; v.funct = c_funct; v.rd = c_rd; v.cond = c_cond; v.af = c_af;
    v.mr = mr; v.st = st; v.wr = wr; v.sel = sel; v.aluctl = aluctl; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_src[4];
`ifdef MC_MEM_HANDSHAKE_EN
    c_mr = 1'b1;
`else
    c_mr = 1'b0;
`endif
    // ADD imm, S=0, AL
    instr(2'b00, 6'b101000, 4'd3, 4'b1110, 4'b1111);
    row(1, c_mr, 4'd0, 4'b0000, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd7, 4'b0000, SEL_B1, 2'b00, 4'b0000);
    row(0, c_mr, 4'd8, 4'b0010, SEL_NO, 2'b00, 4'b0000);
    // SUBS reg: all four flags from ALU
    instr(2'b00, 6'b000101, 4'd4, 4'b1110, 4'b1010);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd6, 4'b0000, SEL_NO, 2'b01, 4'b0000);
    row(0, c_mr, 4'd8, 4'b0010, SEL_NO, 2'b00, 4'b1010);
    // CMP: flags written, no register write
    instr(2'b00, 6'b010101, 4'd5, 4'b1110, 4'b0100);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1010);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1010);
    row(0, c_mr, 4'd6, 4'b0000, SEL_NO, 2'b01, 4'b1010);
    row(0, c_mr, 4'd8, 4'b0000, SEL_NO, 2'b00, 4'b0100);
    // BNE with Z=1: not taken
    instr(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd9, 4'b0000, SEL_BR, 2'b00, 4'b0100);
    // BEQ with Z=1: taken
    instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd9, 4'b1000, SEL_BR, 2'b00, 4'b0100);
    // ANDS: only N,Z updated, C,V kept
    instr(2'b00, 6'b000001, 4'd6, 4'b1110, 4'b1011);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0100);
    row(0, c_mr, 4'd6, 4'b0000, SEL_NO, 2'b10, 4'b0100);
    row(0, c_mr, 4'd8, 4'b0010, SEL_NO, 2'b00, 4'b1000);
    // ORRSEQ to PC with Z=0: fails, no reg/PC/flag write
    instr(2'b00, 6'b011001, 4'd15, 4'b0000, 4'b0101);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd6, 4'b0000, SEL_NO, 2'b11, 4'b1000);
    row(0, c_mr, 4'd8, 4'b0000, SEL_NO, 2'b00, 4'b1000);
    // LDR to PC
    instr(2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b1000);
    row(0, c_mr, 4'd3, 4'b0000, SEL_AD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd4, 4'b1010, SEL_WB, 2'b00, 4'b1000);
    // STRLT with N=1,V=0: executes
    instr(2'b01, 6'b011000, 4'd2, 4'b1011, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b1000);
    row(0, c_mr, 4'd5, 4'b0100, SEL_AD, 2'b00, 4'b1000);
    // STRGE: suppressed, same state walk
    instr(2'b01, 6'b011000, 4'd2, 4'b1010, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b1000);
    row(0, c_mr, 4'd5, 4'b0000, SEL_AD, 2'b00, 4'b1000);
    // Op=11: two cycles
    instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
`ifdef MC_MEM_HANDSHAKE_EN
    // STR stalled three cycles in MEMWRITE, then a stalled FETCH
    instr(2'b01, 6'b011000, 4'd2, 4'b1110, 4'b0000);
    row(0, 1'b1, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd5, 4'b0100, SEL_AD, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd5, 4'b0100, SEL_AD, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd5, 4'b0100, SEL_AD, 2'b00, 4'b1000);
    row(0, 1'b1, 4'd5, 4'b0100, SEL_AD, 2'b00, 4'b1000);
    row(0, 1'b0, 4'd0, 4'b0000, SEL_FD, 2'b00, 4'b1000);
`endif
    // LDR aborted by reset in MEMREAD
    instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b1000);
    row(1, c_mr, 4'd3, 4'b0000, SEL_FD, 2'b00, 4'b1000);
    row(0, c_mr, 4'd0, 4'b1001, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd1, 4'b0000, SEL_FD, 2'b00, 4'b0000);
    row(0, c_mr, 4'd2, 4'b0000, SEL_B1, 2'b00, 4'b0000);

    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; Cond = 4'b1110;
    ALUFlags = 4'b0; mem_ready = c_mr;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].funct; Rd = vecs[i].rd;
      Cond = vecs[i].cond; ALUFlags = vecs[i].af; mem_ready = vecs[i].mr;
      #1;
      chk("state", i, {4'b0, state}, {4'b0, vecs[i].st});
      chk("writes", i, {4'b0, PCWrite, MemWrite, RegWrite, IRWrite}, {4'b0, vecs[i].wr});
      chk("selects", i, {2'b0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, {2'b0, vecs[i].sel});
      chk("alu_control", i, {6'b0, ALUControl}, {6'b0, vecs[i].aluctl});
      chk("flags", i, {4'b0, FLAGS}, {4'b0, vecs[i].flags});
    end

    // ImmSrc/RegSrc follow Op combinationally; reset held keeps the FSM parked.
    exp_src[0] = 4'b0000; exp_src[1] = 4'b0110; exp_src[2] = 4'b1001; exp_src[3] = 4'b1100;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Op = 2'(k);
      #1;
      chk("imm_reg_src", k, {4'b0, ImmSrc, RegSrc}, {4'b0, exp_src[k]});
    end
    @(posedge clk);
    #1;
    chk("reset_state", 0, {4'b0, state}, 8'd0);
    chk("reset_flags", 0, {4'b0, FLAGS}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
